// File: rtl/count_sched_pkg.sv
// rtl/count_sched_pkg.sv - shared types, defaults and helpers for count_scheduler
package count_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 4;
  localparam int NREQ_MAX  = 8;
  localparam int IDW_MAX   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [NREQ_MAX-1:0] onehot(input logic [IDW_MAX-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - winner select; round-robin from ptr with COUNT_SCHED_RR_EN,
// otherwise a lowest-index priority encoder
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
`ifdef COUNT_SCHED_RR_EN
  input  logic [$clog2(NREQ)-1:0] ptr,
`endif
  output logic [$clog2(NREQ)-1:0] win_id,
  output logic                    win_valid
);

  localparam int IDW = $clog2(NREQ);

  always_comb begin
    int base;
    int j;
    win_id    = '0;
    win_valid = 1'b0;
`ifdef COUNT_SCHED_RR_EN
    base = int'(ptr);
`else
    base = 0;
`endif
    // first set bit found walking upward from base, wrapping at NREQ
    for (int k = 0; k < NREQ; k++) begin
      j = (base + k) % NREQ;
      if (!win_valid && req[j]) begin
        win_valid = 1'b1;
        win_id    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/count_scheduler.sv
// rtl/count_scheduler.sv - shares one up-counter among NREQ requesters;
// COUNT_SCHED_RR_EN selects round-robin instead of fixed-priority arbitration
module count_scheduler
  import count_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   len,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [WIDTH-1:0]        count,
  output logic [$clog2(NREQ)-1:0] active_id
);

  localparam int IDW = $clog2(NREQ);

  state_t             state;
  logic [WIDTH-1:0]   lim;
  logic [IDW-1:0]     win_id;
  logic               win_valid;
`ifdef COUNT_SCHED_RR_EN
  logic [IDW-1:0]     ptr;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req),
`ifdef COUNT_SCHED_RR_EN
    .ptr       (ptr),
`endif
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      count     <= '0;
      active_id <= '0;
      lim       <= '0;
`ifdef COUNT_SCHED_RR_EN
      ptr       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // len is captured here only; later changes cannot disturb the run
          if (win_valid) begin
            grant     <= NREQ'(onehot(IDW_MAX'(win_id)));
            active_id <= win_id;
            lim       <= len[int'(win_id)*WIDTH +: WIDTH];
            count     <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (count == lim) begin
            done  <= grant;
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          done  <= '0;
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef COUNT_SCHED_RR_EN
          ptr   <= (int'(active_id) == NREQ-1) ? '0 : active_id + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/count_scheduler.md
# count_scheduler

Shares a single up-counting timer between `NREQ` requesters. Each requester asks for a run of programmable length. The block arbitrates, loads the shared counter, and sequences it from 0 to the granted length. When the run finishes it returns a one-cycle `done` to the owner. It sits between the requesting control logic and the shared counter datapath, so that no requester drives the counter directly.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 4: counter and length width in bits.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  `NREQ`  per-requester request level.
- `len`  in  `NREQ*WIDTH`  packed run lengths; requester i uses `len[i*WIDTH +: WIDTH]`.
- `grant`  out  `NREQ`  one-hot owner of the counter, registered.
- `done`  out  `NREQ`  one-cycle completion pulse to the owner, registered.
- `busy`  out  1  high while any grant is active.
- `count`  out  `WIDTH`  current counter value.
- `active_id`  out  `$clog2(NREQ)`  index of the current or last owner.

## Operation
- FSM states: `IDLE`, `RUN`, `DONE`.
- `IDLE`, no `req`: hold.
- `IDLE`, any `req` bit high:
  - pick winner w;
  - `grant <= onehot(w)`, `active_id <= w`, `lim <= len[w]`, `count <= 0`, `busy <= 1`;
  - go to `RUN`.
- `RUN`:
  - if `count == lim`, go to `DONE` and assert `done[w]` for one cycle;
  - otherwise `count <= count + 1`.
- `DONE`:
  - `done` is high this cycle only;
  - on exit, `grant <= 0`, `busy <= 0`, `count` holds, and the FSM returns to `IDLE`.
- `len` is sampled only at grant. Later changes to `len` have no effect on the current run.
- A requester must keep `req` high until it sees `done`, then drop it on the following edge. A `req` still high in `IDLE` is a new request.
- `req` dropped during `RUN` is ignored: the run completes and `done` still pulses.
- `lim = 0`: `RUN` lasts one cycle with `count = 0`.
- `lim = 2^WIDTH-1`: `count` reaches all ones and never wraps.
- A request arriving during `RUN` or `DONE` waits and is arbitrated in the next `IDLE` cycle.
- Arbitration uses the priority pointer `ptr`. After each `DONE`, `ptr <= (w+1) mod NREQ`. Search order: `ptr`, `ptr+1`, …, wrapping.

## Timing
- Reset values:
  - `grant = 0`, `done = 0`, `busy = 0`, `count = 0`, `active_id = 0`;
  - `ptr = 0`, state `IDLE`.
- Reset mid-run clears everything asynchronously. No `done` is issued for the aborted run.
- `req` seen in `IDLE` at edge t gives `grant` high after edge t.
- `grant` stays high for `lim+2` cycles: `lim+1` in `RUN` plus 1 in `DONE`.
- `done` is coincident with the last `grant` cycle.
- Back-to-back runs always have exactly one `IDLE` cycle with `grant = 0` between them.
- Throughput: one run per `lim+3` cycles.

## Configuration
- `COUNT_SCHED_RR_EN` defined: round-robin arbitration using `ptr` as described above.
- Not defined: fixed priority, lowest index wins. `ptr` is removed, so requester 0 can starve the others.

## Structure
- `count_sched_pkg` holds:
  - the state enum (`IDLE`, `RUN`, `DONE`);
  - default `NREQ`/`WIDTH` constants;
  - the `onehot` helper function.
- Sub-module `rr_arbiter`: combinational winner select from `req` and `ptr`, returning the index and a valid flag. It degenerates to a priority encoder without `COUNT_SCHED_RR_EN`.

## Test plan
- Reset:
  - `reset=0` mid-run with `len[1]=5` → all outputs 0 immediately;
  - after release, no `done` is issued and the next `req[2]` is granted to requester 2.
- Single run: `req[0]=1`, `len[0]=3` → `grant=0001` for 5 cycles, `count` goes 0,1,2,3,3, `done[0]` pulses in the 5th cycle.
- Zero length: `len[3]=0` → `grant=1000` for 2 cycles, `done[3]` in the 2nd cycle.
- Round-robin (macro defined):
  - `req=1111`, all `len=1`, each requester drops `req` after its `done` → grants in order 0,1,2,3;
  - one `IDLE` gap between grants.
- Fixed priority (macro undefined): `req=0110`, `req[1]` re-raised after each `done` → requester 1 always wins and requester 2 is never granted.
- Sampling and abort:
  - `len[0]` changed from 2 to 7 during `RUN` → run ends at `count=2`;
  - `req[0]` dropped mid-run → `done[0]` still pulses.
